// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline constants for the register scoreboard: register count,
// register-index width and the hard-wired zero register.
package reg_scoreboard_pkg;

    localparam int NREG_DEF  = 32;
    localparam int REG_IDX_W = 5;
    localparam int NSLOT     = 2 ** REG_IDX_W;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Issue / write-back / status bundle between decode and the register scoreboard.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic        iss_valid;
    reg_idx_t    iss_src1;
    reg_idx_t    iss_src2;
    logic        iss_use2;
    reg_idx_t    iss_dest;
    logic        iss_we;
    reg_idx_t    wb_dest;
    logic        wb_en;
    logic        stall;
    logic        iss_accept;
    logic        busy;
    logic [31:0] stall_cnt;

    modport master (
        output iss_valid, iss_src1, iss_src2, iss_use2, iss_dest, iss_we,
        output wb_dest, wb_en,
        input  stall, iss_accept, busy, stall_cnt
    );

    modport slave (
        input  iss_valid, iss_src1, iss_src2, iss_use2, iss_dest, iss_we,
        input  wb_dest, wb_en,
        output stall, iss_accept, busy, stall_cnt
    );

endinterface

// File: rtl/sb_counter.sv
// Per-register pending-write counter: saturating up/down, never wraps in
// either direction. value_nxt is exported so the owner can register flags from it.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] value,
    output logic [CNT_W-1:0] value_nxt
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    logic dec_ok;
    logic inc_ok;

    always_comb begin
        dec_ok    = dec && (value != '0);
        // a full counter may still take an increment when a decrement lands alongside it
        inc_ok    = inc && ((value != CMAX) || dec_ok);
        value_nxt = value;
        if (inc_ok && !dec_ok) begin
            value_nxt = value + 1'b1;
        end else if (dec_ok && !inc_ok) begin
            value_nxt = value - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else begin
            value <= value_nxt;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: counts in-flight writes per register and stalls issue on
// RAW hazards or a full counter. Same-cycle write-back releases the hazard.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             rst,
    reg_scoreboard_if.slave sb
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [CNT_W-1:0] pend     [NSLOT];
    logic [CNT_W-1:0] pend_nxt [NSLOT];
    logic [CNT_W-1:0] eff      [NSLOT];
    logic             raw_hit;
    logic             cap_hit;
    logic             stall_c;
    logic             any_nxt;
    logic             busy_q;
    logic [31:0]      stall_cnt_q;

    for (genvar r = 0; r < NSLOT; r++) begin : g_reg
        if (r == 0 || r >= NREG) begin : g_none
            assign pend[r]     = '0;
            assign pend_nxt[r] = '0;
            assign eff[r]      = '0;
        end else begin : g_cnt
            logic inc;
            logic dec;
            assign inc = sb.iss_accept && sb.iss_we && (sb.iss_dest == reg_idx_t'(r));
            assign dec = sb.wb_en && (sb.wb_dest == reg_idx_t'(r));
            // register file writes on the falling edge, so this cycle's write-back is visible
            assign eff[r] = (dec && (pend[r] != '0)) ? pend[r] - 1'b1 : pend[r];

            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc       (inc),
                .dec       (dec),
                .value     (pend[r]),
                .value_nxt (pend_nxt[r])
            );
        end
    end

    always_comb begin
        raw_hit = (eff[sb.iss_src1] != '0) || (sb.iss_use2 && (eff[sb.iss_src2] != '0));
        cap_hit = sb.iss_we && (sb.iss_dest != ZERO_REG) && (eff[sb.iss_dest] == CMAX);
        stall_c = !rst && sb.iss_valid && (raw_hit || cap_hit);
    end

    always_comb begin
        any_nxt = 1'b0;
        for (int r = 0; r < NSLOT; r++) begin
            any_nxt = any_nxt | (pend_nxt[r] != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            busy_q <= any_nxt;
            if (stall_c) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign sb.stall      = stall_c;
    assign sb.iss_accept = sb.iss_valid && !stall_c;
    assign sb.busy       = busy_q;
    assign sb.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_scoreboard;
    import reg_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_scoreboard_if sb ();

    reg_scoreboard #(.NREG(32), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    typedef struct {
        int          id;
        logic        v;
        logic        stall;
        logic        busy;
        logic [31:0] cnt;
        int          probe;
        logic [1:0]  pend;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_vec = 0;
    int   n_err = 0;
    int   vid   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input int s1, input int s2, input logic u2,
                         input int d, input logic we, input int wbd, input logic wbe);
        sb.iss_valid = v;
        sb.iss_src1  = 5'(s1);
        sb.iss_src2  = 5'(s2);
        sb.iss_use2  = u2;
        sb.iss_dest  = 5'(d);
        sb.iss_we    = we;
        sb.wb_dest   = 5'(wbd);
        sb.wb_en     = wbe;
    endtask

    // one clock of stimulus; expected outputs are checked at the following negedge
    task automatic cyc(input logic v, input int s1, input int s2, input logic u2,
                       input int d, input logic we, input int wbd, input logic wbe,
                       input logic es, input logic eb, input logic [31:0] ec,
                       input int probe, input logic [1:0] ep);
        exp_t x;
        @(posedge clk);
        #1;
        drive(v, s1, s2, u2, d, we, wbd, wbe);
        x.id = vid; x.v = v; x.stall = es; x.busy = eb; x.cnt = ec;
        x.probe = probe; x.pend = ep;
        q.push_back(x);
        vid++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("v%0d stall", e.id), 32'(sb.stall), 32'(e.stall));
                chk($sformatf("v%0d accept", e.id), 32'(sb.iss_accept), 32'(e.v && !e.stall));
                chk($sformatf("v%0d busy", e.id), 32'(sb.busy), 32'(e.busy));
                chk($sformatf("v%0d stall_cnt", e.id), sb.stall_cnt, e.cnt);
                if (e.probe >= 0)
                    chk($sformatf("v%0d pend[%0d]", e.id, e.probe), 32'(dut.pend[e.probe]), 32'(e.pend));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1, 3, 3, 1, 3, 1, 0, 0);
        #12;
        chk("reset stall", 32'(sb.stall), 32'd0);
        chk("reset accept", 32'(sb.iss_accept), 32'd1);
        chk("reset busy", 32'(sb.busy), 32'd0);
        chk("reset stall_cnt", sb.stall_cnt, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;

        // r0 never tracked or stalled
        cyc(1, 0, 0, 1, 0, 0, 0, 0,  0, 0, 0, -1, 0);
        cyc(1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, -1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0);
        // RAW on r5, released by same-cycle write-back
        cyc(1, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0,  5, 0);
        cyc(1, 5, 0, 0, 0, 0, 0, 0,  1, 1, 0,  5, 1);
        cyc(1, 5, 0, 0, 0, 0, 5, 1,  0, 1, 1,  5, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1,  5, 0);
        // capacity on r7
        cyc(1, 0, 0, 0, 7, 1, 0, 0,  0, 0, 1,  7, 0);
        cyc(1, 0, 0, 0, 7, 1, 0, 0,  0, 1, 1,  7, 1);
        cyc(1, 0, 0, 0, 7, 1, 0, 0,  0, 1, 1,  7, 2);
        cyc(1, 0, 0, 0, 7, 1, 0, 0,  1, 1, 1,  7, 3);
        cyc(1, 0, 0, 0, 7, 1, 7, 1,  0, 1, 2,  7, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 2,  7, 3);
        // src2 only matters with use2
        cyc(1, 0, 7, 0, 0, 0, 0, 0,  0, 1, 2, -1, 0);
        cyc(1, 0, 7, 1, 0, 0, 0, 0,  1, 1, 2, -1, 0);
        // simultaneous inc/dec on r9, stray write-back to r12
        cyc(1, 0, 0, 0, 9, 1, 0, 0,  0, 1, 3,  9, 0);
        cyc(1, 0, 0, 0, 9, 1, 9, 1,  0, 1, 3,  9, 1);
        cyc(0, 0, 0, 0, 0, 0, 12, 1, 0, 1, 3,  9, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 3, 12, 0);
        // drain, then underflow attempt on r5
        cyc(0, 0, 0, 0, 0, 0, 7, 1,  0, 1, 3,  7, 3);
        cyc(0, 0, 0, 0, 0, 0, 7, 1,  0, 1, 3,  7, 2);
        cyc(0, 0, 0, 0, 0, 0, 7, 1,  0, 1, 3,  7, 1);
        cyc(0, 0, 0, 0, 0, 0, 9, 1,  0, 1, 3,  7, 0);
        cyc(0, 0, 0, 0, 0, 0, 5, 1,  0, 0, 3,  9, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 3,  5, 0);
        // pend[3]=2, stall_cnt up to 40, then async reset mid-cycle
        cyc(1, 0, 0, 0, 3, 1, 0, 0,  0, 0, 3,  3, 0);
        cyc(1, 0, 0, 0, 3, 1, 0, 0,  0, 1, 3,  3, 1);
        for (int i = 0; i < 37; i++)
            cyc(1, 3, 0, 0, 0, 0, 0, 0,  1, 1, 32'(3 + i), -1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 40, 3, 2);
        @(negedge clk);
        #2;
        drive(1, 3, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(sb.busy), 32'd0);
        chk("midrst stall_cnt", sb.stall_cnt, 32'd0);
        chk("midrst pend[3]", 32'(dut.pend[3]), 32'd0);
        chk("midrst stall", 32'(sb.stall), 32'd0);
        chk("midrst accept", 32'(sb.iss_accept), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 3, 1,  0, 0, 0,  3, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  3, 0);
        // stall_cnt wrap
        @(posedge clk);
        #1 force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        cyc(1, 0, 0, 0, 4, 1, 0, 0,  0, 0, 32'hFFFF_FFFF, 4, 0);
        cyc(1, 4, 0, 0, 0, 0, 0, 0,  1, 1, 32'hFFFF_FFFF, 4, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0,  4, 1);
        cyc(0, 0, 0, 0, 0, 0, 4, 1,  0, 1, 0,  4, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,  4, 0);

        repeat (2) @(posedge clk);
        chk("queue drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers tracked.
REQ-002 Parameter CNT_W, default 2, width of each per-register pending-write counter; maximum in-flight writes per register = 2^CNT_W-1.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 iss_valid  input  1  decode stage presents an instruction for issue.
REQ-006 iss_src1  input  5  first source register index.
REQ-007 iss_src2  input  5  second source register index.
REQ-008 iss_use2  input  1  instruction reads iss_src2; when low, src2 is ignored.
REQ-009 iss_dest  input  5  destination register index.
REQ-010 iss_we  input  1  instruction writes iss_dest.
REQ-011 wb_dest  input  5  write-back destination; same value driven to the register file dest port.
REQ-012 wb_en  input  1  write-back valid; same value driven to the register file Write_EN port.
REQ-013 stall  output  1  combinational; issue must hold this cycle.
REQ-014 iss_accept  output  1  combinational; iss_valid AND NOT stall.
REQ-015 busy  output  1  registered; high when any counter is non-zero.
REQ-016 stall_cnt  output  32  registered count of cycles with iss_valid and stall both high.

Function
REQ-017 Per-register counter pend[r], r in 1..NREG-1; register 0 never tracked, reads as 0, never stalls.
REQ-018 Effective pending eff[r] = pend[r] - 1 when wb_en high and wb_dest = r, else pend[r]; decrement taken only when pend[r] > 0.
REQ-019 Same-cycle write-back clears a RAW hazard: the register file writes on the falling edge, so read data is valid before the next rising edge.
REQ-020 RAW stall when iss_valid and eff[iss_src1] != 0, or iss_use2 and eff[iss_src2] != 0.
REQ-021 Capacity stall when iss_valid, iss_we, iss_dest != 0, and eff[iss_dest] = 2^CNT_W-1.
REQ-022 stall = RAW stall OR capacity stall; stall low whenever iss_valid low.
REQ-023 On rising edge: pend[r] increments by 1 when iss_accept, iss_we, iss_dest = r (r != 0).
REQ-024 On rising edge: pend[r] decrements by 1 when wb_en, wb_dest = r, pend[r] > 0.
REQ-025 Simultaneous increment and decrement on the same r leaves pend[r] unchanged.
REQ-026 Write-back to a register with pend = 0, or to r0, is ignored; counters never underflow.
REQ-027 Counters never overflow; REQ-021 guarantees it.
REQ-028 busy registered from next-state counters: high in the cycle after any counter becomes non-zero.
REQ-029 stall_cnt increments by 1 per cycle with iss_valid and stall high; wraps 0xFFFFFFFF -> 0.
REQ-030 No WAW stall; multiple in-flight writes to one register are counted, not blocked.

Reset
REQ-031 rst high forces all pend[r] = 0, busy = 0, stall_cnt = 0 immediately, regardless of clk.
REQ-032 Reset mid-operation discards all pending state; write-backs after reset release are ignored per REQ-026.
REQ-033 While rst high, stall = 0 and iss_accept = iss_valid.

Structure
REQ-034 Shared pipeline package holds NREG, register-index width 5, and the zero-register constant.
REQ-035 One sub-module, sb_counter: single saturating up/down counter with inc, dec, and value outputs, instantiated NREG-1 times.
REQ-036 Hazard compare and stall logic in the top level; no memories, flip-flops only.

Verification
REQ-037 Issue dest=5, we=1, accepted; next cycle issue src1=5 with no write-back -> stall=1, stall_cnt 0->1; wb_en=1, wb_dest=5 in a later cycle -> stall=0 that same cycle, pend[5]=0 after edge.
REQ-038 Issue src1=0, src2=0, use2=1 with pend all 0 -> stall=0; issue dest=0, we=1 -> pend unchanged, busy stays 0.
REQ-039 Three accepted issues to dest=7 -> pend[7]=3; fourth issue dest=7, we=1 -> capacity stall; same cycle wb_dest=7 -> stall=0, pend[7] stays 3.
REQ-040 Same-cycle accepted issue dest=9 and wb_dest=9 with pend[9]=1 -> pend[9]=1 after edge; wb_dest=12 with pend[12]=0 -> no change.
REQ-041 pend[3]=2, busy=1, stall_cnt=40; assert rst between clock edges -> all zero immediately; release, wb_dest=3 -> pend[3] remains 0.
REQ-042 Preload stall_cnt to 0xFFFFFFFF via forced stall cycles -> one further stall cycle gives stall_cnt=0.
